// File: rtl/shift_reg_serializer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : shift_reg_pkg                                            |
// | Shared types and constants for the parallel-in/serial-out shifter  |
// | and the serial blocks that reuse its bit counter.                  |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package shift_reg_pkg;

   // Shifter states: waiting for a word, or streaming one out
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } shift_state_t;

   // Shift direction selectors for the LSB_FIRST parameter
   localparam int SHIFT_MSB_FIRST = 0;
   localparam int SHIFT_LSB_FIRST = 1;

   // Counter width able to hold every value 0..w inclusive
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage : shift_reg_pkg
`default_nettype wire

// File: rtl/shift_reg_serializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : shift_reg_serializer_if                                |
// | Load handshake and serial output bundle of the shifter.            |
// | The slave modport is the shifter side, master is the word source.  |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
interface shift_reg_serializer_if
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) ();

   localparam int CW = cnt_width(WIDTH);

   logic [WIDTH-1:0] load_data;
   logic             load_valid;
   logic             load_ready;
   logic             shift_enable;
   logic             data_out;
   logic             busy;
   logic             done;
   logic [CW-1:0]    bits_left;

   modport master (
      output load_data, load_valid, shift_enable,
      input  load_ready, data_out, busy, done, bits_left
   );

   modport slave (
      input  load_data, load_valid, shift_enable,
      output load_ready, data_out, busy, done, bits_left
   );

endinterface : shift_reg_serializer_if
`default_nettype wire

// File: rtl/shift_reg_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : shift_reg_counter                                         |
// | Loadable down-counter that saturates at zero, with last (==1) and  |
// | zero flags. Shared by the serial blocks to track bits remaining.   |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module shift_reg_counter #(
   parameter int CW = 4
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          load,
   input  wire logic [CW-1:0] load_value,
   input  wire logic          dec,
   output logic      [CW-1:0] count,
   output logic               last,
   output logic               zero
);

   logic [CW-1:0] r_count;

   // Load has priority over decrement; decrement stops at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_value;
      end else if (dec && (r_count != '0)) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign count = r_count;
   assign last  = (r_count == CW'(1));
   assign zero  = (r_count == '0);

endmodule : shift_reg_counter
`default_nettype wire

// File: rtl/shift_reg_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : shift_reg_serializer                                      |
// | Parametrised parallel-in/serial-out shifter with valid/ready load, |
// | bit counter and a one-cycle done pulse. Words stream back-to-back  |
// | with no idle bit when the next word is offered on the last shift.  |
// | Option macro SHIFT_REG_SERIAL_IN_EN adds serial_in (shift fill)    |
// | and parallel_out (register contents) for simultaneous SIPO use.    |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module shift_reg_serializer
   import shift_reg_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = SHIFT_MSB_FIRST
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
`ifdef SHIFT_REG_SERIAL_IN_EN
   input  wire logic             serial_in,
   output logic      [WIDTH-1:0] parallel_out,
`endif
   shift_reg_serializer_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);

   shift_state_t     r_state;
   shift_state_t     w_state_nxt;
   logic [WIDTH-1:0] r_shreg;
   logic             r_done;
   logic [CW-1:0]    w_count;
   logic             w_cnt_last;
   logic             w_cnt_zero;
   logic             w_shift;
   logic             w_last_shift;
   logic             w_load_ready;
   logic             w_load;
   logic             w_fill;

`ifdef SHIFT_REG_SERIAL_IN_EN
   assign w_fill       = serial_in;
   assign parallel_out = r_shreg;
`else
   assign w_fill       = 1'b0;
`endif

   // A shift only happens while a word is in flight; the last one frees the slot
   assign w_shift      = (r_state == SHIFT) && bus.shift_enable;
   assign w_last_shift = w_shift && w_cnt_last;
   assign w_load_ready = (r_state == IDLE) || w_last_shift;
   assign w_load       = bus.load_valid && w_load_ready;

   shift_reg_counter #(
      .CW (CW)
   ) u_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (w_load),
      .load_value (CW'(WIDTH)),
      .dec        (w_shift),
      .count      (w_count),
      .last       (w_cnt_last),
      .zero       (w_cnt_zero)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: a load always (re)enters SHIFT, otherwise the last shift ends the word
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_load) begin
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (w_load) begin
               w_state_nxt = SHIFT;
            end else if (w_last_shift || w_cnt_zero) begin
               // Zero count in SHIFT is unreachable; returning to IDLE avoids a stuck busy
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Shift register: a new word overrides the shift of the old word's last bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg <= '0;
      end else if (w_load) begin
         r_shreg <= bus.load_data;
      end else if (w_shift) begin
         if (LSB_FIRST == SHIFT_LSB_FIRST) begin
            r_shreg <= {w_fill, r_shreg[WIDTH-1:1]};
         end else begin
            r_shreg <= {r_shreg[WIDTH-2:0], w_fill};
         end
      end
   end

   // Completion pulse follows every last shift, including back-to-back reloads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
      end else begin
         r_done <= w_last_shift;
      end
   end

   assign bus.load_ready = w_load_ready;
   assign bus.busy       = (r_state == SHIFT);
   assign bus.done       = r_done;
   assign bus.bits_left  = w_count;
   assign bus.data_out   = (r_state == SHIFT) ?
                           ((LSB_FIRST == SHIFT_LSB_FIRST) ? r_shreg[0] : r_shreg[WIDTH-1]) :
                           1'b0;

endmodule : shift_reg_serializer
`default_nettype wire

// File: tb/tb_shift_reg_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_shift_reg_serializer                                   |
// | Self-checking bench: an MSB-first and an LSB-first instance share  |
// | one stimulus; each is compared every cycle against a queue model   |
// | holding the bits of the word still to be sent.                     |
// | Option macro SHIFT_REG_SERIAL_IN_EN enables the SIPO checks.       |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_shift_reg_serializer;
   import shift_reg_pkg::*;

   localparam int WIDTH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   shift_reg_serializer_if #(.WIDTH(WIDTH)) bm ();
   shift_reg_serializer_if #(.WIDTH(WIDTH)) bl ();

`ifdef SHIFT_REG_SERIAL_IN_EN
   logic             serial_in = 1'b0;
   logic [WIDTH-1:0] po_m;
   logic [WIDTH-1:0] po_l;
`endif

   shift_reg_serializer #(.WIDTH(WIDTH), .LSB_FIRST(SHIFT_MSB_FIRST)) u_msb (
      .clk          (clk),
      .rst_n        (rst_n),
`ifdef SHIFT_REG_SERIAL_IN_EN
      .serial_in    (serial_in),
      .parallel_out (po_m),
`endif
      .bus          (bm.slave)
   );

   shift_reg_serializer #(.WIDTH(WIDTH), .LSB_FIRST(SHIFT_LSB_FIRST)) u_lsb (
      .clk          (clk),
      .rst_n        (rst_n),
`ifdef SHIFT_REG_SERIAL_IN_EN
      .serial_in    (serial_in),
      .parallel_out (po_l),
`endif
      .bus          (bl.slave)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: bits still to be sent, in transmission order
   bit qm[$];
   bit ql[$];
   bit dm = 1'b0;
   bit dl = 1'b0;

   bit recording = 1'b0;
   bit rec_m[$];
   bit rec_l[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit se);
      bm.load_valid   = v;  bl.load_valid   = v;
      bm.load_data    = d;  bl.load_data    = d;
      bm.shift_enable = se; bl.shift_enable = se;
   endtask

   task automatic check_all(input bit se);
      chk("m.load_ready", bm.load_ready, (qm.size() == 0) || (se && qm.size() == 1));
      chk("m.busy",       bm.busy,       qm.size() != 0);
      chk("m.data_out",   bm.data_out,   (qm.size() != 0) ? qm[0] : 1'b0);
      chk("m.done",       bm.done,       dm);
      chk("m.bits_left",  bm.bits_left,  qm.size());
      chk("l.load_ready", bl.load_ready, (ql.size() == 0) || (se && ql.size() == 1));
      chk("l.busy",       bl.busy,       ql.size() != 0);
      chk("l.data_out",   bl.data_out,   (ql.size() != 0) ? ql[0] : 1'b0);
      chk("l.done",       bl.done,       dl);
      chk("l.bits_left",  bl.bits_left,  ql.size());
   endtask

   task automatic model_update(input bit v, input logic [WIDTH-1:0] d, input bit se);
      bit rdy_m;
      bit rdy_l;
      rdy_m = (qm.size() == 0) || (se && qm.size() == 1);
      rdy_l = (ql.size() == 0) || (se && ql.size() == 1);
      dm = se && (qm.size() == 1);
      dl = se && (ql.size() == 1);
      if (se && qm.size() > 0) void'(qm.pop_front());
      if (se && ql.size() > 0) void'(ql.pop_front());
      if (v && rdy_m) begin
         qm.delete();
         for (int i = WIDTH - 1; i >= 0; i--) qm.push_back(d[i]);
      end
      if (v && rdy_l) begin
         ql.delete();
         for (int i = 0; i < WIDTH; i++) ql.push_back(d[i]);
      end
   endtask

   // One clock: drive, check before the edge, advance the model, move past the edge
   task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit se);
      drive(v, d, se);
      #3;
      check_all(se);
      if (recording && se && qm.size() > 0) rec_m.push_back(bm.data_out);
      if (recording && se && ql.size() > 0) rec_l.push_back(bl.data_out);
      model_update(v, d, se);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values();
      chk("m.rst_load_ready", bm.load_ready, 1'b1);
      chk("m.rst_busy",       bm.busy,       1'b0);
      chk("m.rst_done",       bm.done,       1'b0);
      chk("m.rst_data_out",   bm.data_out,   1'b0);
      chk("m.rst_bits_left",  bm.bits_left,  0);
      chk("l.rst_load_ready", bl.load_ready, 1'b1);
      chk("l.rst_busy",       bl.busy,       1'b0);
      chk("l.rst_done",       bl.done,       1'b0);
      chk("l.rst_data_out",   bl.data_out,   1'b0);
      chk("l.rst_bits_left",  bl.bits_left,  0);
`ifdef SHIFT_REG_SERIAL_IN_EN
      chk("m.rst_parallel_out", po_m, 0);
      chk("l.rst_parallel_out", po_l, 0);
`endif
   endtask

   function automatic logic [31:0] pack(input bit q[$]);
      logic [31:0] r;
      r = '0;
      foreach (q[i]) r = {r[30:0], q[i]};
      return r;
   endfunction

   task automatic start_rec();
      rec_m.delete();
      rec_l.delete();
      recording = 1'b1;
   endtask

   initial begin
      drive(1'b0, '0, 1'b0);

      // Reset state while reset is asserted, then release away from the edge
      #1;
      check_reset_values();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Idle with no offers: nothing moves
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
      // shift_enable while idle must also be ignored
      step(1'b0, '0, 1'b1);

      // 0xA5 with continuous shift_enable
      step(1'b1, 8'hA5, 1'b0);
      start_rec();
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
      recording = 1'b0;
      step(1'b0, '0, 1'b0);
      chk("m.seq_A5", pack(rec_m), 32'hA5);
      chk("l.seq_A5", pack(rec_l), 32'hA5);

      // 0xA5 with shift_enable toggling 1,0,1,0...
      step(1'b1, 8'hA5, 1'b0);
      start_rec();
      for (int i = 0; i < 16; i++) step(1'b0, '0, (i % 2) == 0);
      recording = 1'b0;
      step(1'b0, '0, 1'b0);
      chk("m.seq_A5_stall", pack(rec_m), 32'hA5);
      chk("l.seq_A5_stall", pack(rec_l), 32'hA5);

      // Back-to-back: 0xF0 then 0x0F offered on the 8th shift
      step(1'b1, 8'hF0, 1'b0);
      start_rec();
      for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
      step(1'b1, 8'h0F, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
      recording = 1'b0;
      step(1'b0, '0, 1'b0);
      chk("m.seq_b2b", pack(rec_m), 32'hF00F);
      chk("l.seq_b2b", pack(rec_l), 32'h0FF0);

      // Reset mid-word after 3 shifts of 0xFF
      step(1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values();
      qm.delete(); ql.delete();
      dm = 1'b0;   dl = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

`ifdef SHIFT_REG_SERIAL_IN_EN
      // Serial capture of 1,1,0,0,1,0,1,1 while sending 0x00
      begin
         logic [7:0] sin_bits;
         sin_bits = 8'b1100_1011;
         step(1'b1, 8'h00, 1'b0);
         for (int i = 7; i >= 0; i--) begin
            serial_in = sin_bits[i];
            step(1'b0, '0, 1'b1);
         end
         serial_in = 1'b0;
         chk("m.parallel_out", po_m, 8'hCB);
         chk("l.parallel_out", po_l, 8'hD3);
         step(1'b0, '0, 1'b0);
      end
`endif

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), WIDTH'($urandom), $urandom_range(0, 3) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_shift_reg_serializer
`default_nettype wire

// File: doc/shift_reg_serializer.md
# shift_reg_serializer

Parametrised parallel-in/serial-out shifter with a valid/ready load handshake, a bit counter and a completion pulse. It replaces the fixed 8-bit shift register wherever a word must be serialised onto a one-bit line, such as a display, LED chain or SPI-style output. Width and shift direction are parameters. Back-to-back words stream out with no idle gap.

## Interface
Parameters:
- `WIDTH`, default 8: word width in bits, ≥ 2.
- `LSB_FIRST`, default 0: 0 = shift out MSB first; 1 = shift out LSB first.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `load_data`, in, `WIDTH`: parallel word to serialise.
- `load_valid`, in, 1: `load_data` is offered.
- `load_ready`, out, 1: the shifter can accept a word this cycle.
- `shift_enable`, in, 1: advance one bit this cycle; ignored when idle.
- `data_out`, out, 1: current serial bit.
- `busy`, out, 1: a word is being shifted.
- `done`, out, 1: one-cycle pulse after the last bit of a word has shifted.
- `bits_left`, out, `$clog2(WIDTH+1)`: bits still to be shifted.

## Operation
- **States:** IDLE, SHIFT.
- **Load:** a load is accepted when `load_valid && load_ready`.
  - The register takes `load_data`, `bits_left` takes `WIDTH`, and the state goes to SHIFT.
- **`load_ready` (combinational):** `(state==IDLE) || (state==SHIFT && shift_enable && bits_left==1)`.
- **Shift (SHIFT state with `shift_enable`):**
  - MSB-first: register becomes `{reg[WIDTH-2:0], fill}`.
  - LSB-first: register becomes `{fill, reg[WIDTH-1:1]}`.
  - `bits_left` decrements by 1.
- **Last shift (`bits_left==1`):**
  - With no load accepted, the state returns to IDLE and `bits_left` becomes 0.
  - If a load is accepted in the same cycle, the load wins. The state stays SHIFT, the register takes the new word and `bits_left` becomes `WIDTH`.
- **`done`:** registered. It is high in the cycle after any last shift, including a back-to-back load.
- **`data_out`:** `busy ? (LSB_FIRST ? reg[0] : reg[WIDTH-1]) : 0`.
- **`busy`:** `state==SHIFT`.
- **`fill`:** 0, unless the serial-input option below is compiled in.
- **Idle:** `shift_enable` in IDLE has no effect on the register or the counter.
- **`bits_left` range:** it never wraps below 0 and never exceeds `WIDTH`.
- **Reset mid-word:** the word is aborted immediately, with no `done` pulse.
- **Reset values:**
  - register = 0, state = IDLE, `bits_left` = 0.
  - `busy` = 0, `done` = 0, `data_out` = 0, `load_ready` = 1.

## Timing
- **Load to output:** the first bit appears on `data_out` in the cycle after the load edge.
- **Per bit:** each accepted `shift_enable` presents the next bit after that edge.
- **Total:** a word occupies exactly `WIDTH` `shift_enable` cycles. Gaps in `shift_enable` stall the shift without losing state.
- **`done` latency:** one cycle after the edge that shifted the last bit.
- **Back-to-back:** the streaming rate is one bit per cycle continuously, with no bubble between words.
- **Paths:** `load_ready` has a combinational path from `shift_enable`. There is no combinational path from `load_valid` to any output.

## Configuration
Macro: `SHIFT_REG_SERIAL_IN_EN`.
- **Defined:**
  - Adds port `serial_in`, in, 1: its value is used as `fill` on every shift.
  - Adds port `parallel_out`, out, `WIDTH`: the register contents at all times.
  - After `WIDTH` shifts, `parallel_out` holds the captured word, giving SIPO receive alongside PISO transmit.
  - `parallel_out` resets to 0.
- **Not defined:**
  - Neither port exists and `fill` is 0.
  - The register is all zeros after a completed word.

## Structure
- **Package `shift_reg_pkg`:**
  - `shift_state_t` enum, holding IDLE and SHIFT.
  - Direction constants `SHIFT_MSB_FIRST` = 0 and `SHIFT_LSB_FIRST` = 1.
  - The `$clog2(WIDTH+1)` width function for the counter.
- **Sub-module `shift_reg_counter`:**
  - Loadable down-counter with `load`, `dec` and `count` ports.
  - Flags `last` (count==1) and `zero`.
  - Reused by other serial blocks.
- **Top level:** the shift register, the state machine and the `done` register stay in `shift_reg_serializer`.

## Test plan
- Reset, then hold `load_valid`=0 for 4 cycles. Required: `load_ready`=1, `busy`=0, `done`=0, `data_out`=0, `bits_left`=0 throughout.
- `WIDTH`=8, MSB-first, load 0xA5, then `shift_enable` held for 8 cycles.
  - `data_out` sequence must be 1,0,1,0,0,1,0,1.
  - `done` must be high exactly one cycle later and `busy` low.
- `LSB_FIRST`=1, load 0xA5, then `shift_enable` toggled 1,0,1,0,...
  - Sequence must be 1,0,1,0,0,1,0,1, with each bit held across the stall cycles.
  - `bits_left` must count 8 down to 0.
- Back-to-back: load 0xF0, then on the 8th shift offer 0x0F with `load_valid`=1. Required: 16 contiguous bits 1111000000001111, `busy` never low, and `done` pulsed once after the 8th shift.
- Pulse `rst_n` low after 3 shifts of 0xFF. Required: all outputs return to reset values asynchronously and no `done` pulse occurs.
- With `SHIFT_REG_SERIAL_IN_EN` defined:
  - Load 0x00 and drive `serial_in` with 1,1,0,0,1,0,1,1 over 8 shifts, MSB-first. `parallel_out` must equal 0xCB.
  - Without the macro, the same bench must build without the two ports.
